// File: rtl/rf_write_arbiter.sv
// Regfile write-port arbiter: the processor always wins, and two peripherals are buffered in one-deep slots drained round-robin.
// Optional starvation monitor is enabled by defining RF_WRITE_ARBITER_STARVE_EN.
module rf_write_arbiter #(
   parameter int DATA_W     = 32,
   parameter int REG_W      = 5,
   parameter int STARVE_MAX = 15
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_proc_we,
   input  logic [REG_W-1:0]  i_proc_wreg,
   input  logic [DATA_W-1:0] i_proc_wdata,
   input  logic              i_p0_req,
   input  logic [REG_W-1:0]  i_p0_wreg,
   input  logic [DATA_W-1:0] i_p0_wdata,
   output logic              o_p0_ack,
   input  logic              i_p1_req,
   input  logic [REG_W-1:0]  i_p1_wreg,
   input  logic [DATA_W-1:0] i_p1_wdata,
   output logic              o_p1_ack,
   output logic              o_rf_we,
   output logic [REG_W-1:0]  o_rf_wreg,
   output logic [DATA_W-1:0] o_rf_wdata,
   output logic [1:0]        o_rf_src,
   output logic              o_busy,
   output logic              o_starve
);

   logic [1:0]              r_pend;
   logic                    r_ptr;
   logic [1:0][REG_W-1:0]   r_slot_wreg;
   logic [1:0][DATA_W-1:0]  r_slot_wdata;

   logic [1:0]              w_req, w_ack, w_cap, w_drain, w_pend_nxt;
   logic [1:0][REG_W-1:0]   w_req_wreg;
   logic [1:0][DATA_W-1:0]  w_req_wdata;
   logic                    w_sel_vld, w_sel_idx, w_ptr_nxt;

   assign w_req       = {i_p1_req, i_p0_req};
   assign w_ack       = {o_p1_ack, o_p0_ack};
   assign w_req_wreg  = {i_p1_wreg, i_p0_wreg};
   assign w_req_wdata = {i_p1_wdata, i_p0_wdata};

   // A slot being drained this cycle still blocks capture; it reopens next cycle.
   assign w_cap      = w_req & ~r_pend & ~w_ack;
   assign w_drain    = w_sel_vld ? (w_sel_idx ? 2'b10 : 2'b01) : 2'b00;
   assign w_pend_nxt = (r_pend & ~w_drain) | w_cap;

   always_comb begin
      w_sel_vld = 1'b0;
      w_sel_idx = 1'b0;
      w_ptr_nxt = r_ptr;
      if (!i_proc_we) begin
         if (&r_pend) begin
            w_sel_vld = 1'b1;
            w_sel_idx = r_ptr;
            w_ptr_nxt = ~r_ptr;
         end else if (r_pend[0]) begin
            w_sel_vld = 1'b1;
            w_sel_idx = 1'b0;
            w_ptr_nxt = 1'b1;
         end else if (r_pend[1]) begin
            w_sel_vld = 1'b1;
            w_sel_idx = 1'b1;
            w_ptr_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_pend       <= '0;
         r_ptr        <= 1'b0;
         r_slot_wreg  <= '0;
         r_slot_wdata <= '0;
         o_p0_ack     <= 1'b0;
         o_p1_ack     <= 1'b0;
         o_busy       <= 1'b0;
         o_rf_we      <= 1'b0;
         o_rf_wreg    <= '0;
         o_rf_wdata   <= '0;
         o_rf_src     <= 2'b00;
      end else begin
         r_pend   <= w_pend_nxt;
         r_ptr    <= w_ptr_nxt;
         o_p0_ack <= w_cap[0];
         o_p1_ack <= w_cap[1];
         o_busy   <= |w_pend_nxt;
         for (int k = 0; k < 2; k++) begin
            if (w_cap[k]) begin
               r_slot_wreg[k]  <= w_req_wreg[k];
               r_slot_wdata[k] <= w_req_wdata[k];
            end
         end
         if (i_proc_we) begin
            o_rf_we    <= 1'b1;
            o_rf_wreg  <= i_proc_wreg;
            o_rf_wdata <= i_proc_wdata;
            o_rf_src   <= 2'b01;
         end else if (w_sel_vld) begin
            // r0 writes from a peripheral still drain and report a source, but never strobe the regfile.
            o_rf_we    <= |r_slot_wreg[w_sel_idx];
            o_rf_wreg  <= r_slot_wreg[w_sel_idx];
            o_rf_wdata <= r_slot_wdata[w_sel_idx];
            o_rf_src   <= {1'b1, w_sel_idx};
         end else begin
            o_rf_we  <= 1'b0;
            o_rf_src <= 2'b00;
         end
      end
   end

`ifdef RF_WRITE_ARBITER_STARVE_EN
   localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(STARVE_MAX);

   logic [1:0][CNT_W-1:0] r_age, w_age_nxt;
   logic                  r_starve;

   always_comb begin
      w_age_nxt = r_age;
      for (int k = 0; k < 2; k++) begin
         if (!r_pend[k] || w_drain[k])
            w_age_nxt[k] = '0;
         else if (r_age[k] != AGE_MAX)
            w_age_nxt[k] = r_age[k] + 1'b1;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_age    <= '0;
         r_starve <= 1'b0;
      end else begin
         r_age <= w_age_nxt;
         if (w_age_nxt[0] == AGE_MAX || w_age_nxt[1] == AGE_MAX)
            r_starve <= 1'b1;
      end
   end

   assign o_starve = r_starve;
`else
   assign o_starve = (STARVE_MAX < 0);
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed literal checks plus random traffic against a cycle-level reference model.
module tb_rf_write_arbiter;
   localparam int DW = 32;
   localparam int RW = 5;
   localparam int SM = 15;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          proc_we;
   logic [RW-1:0] proc_wreg;
   logic [DW-1:0] proc_wdata;
   logic          req [2];
   logic [RW-1:0] rwreg [2];
   logic [DW-1:0] rwdata [2];
   logic          ack [2];
   logic          rf_we, busy, starve;
   logic [RW-1:0] rf_wreg;
   logic [DW-1:0] rf_wdata;
   logic [1:0]    rf_src;

   rf_write_arbiter #(.DATA_W(DW), .REG_W(RW), .STARVE_MAX(SM)) dut (
      .i_clock(clk), .i_reset(rst),
      .i_proc_we(proc_we), .i_proc_wreg(proc_wreg), .i_proc_wdata(proc_wdata),
      .i_p0_req(req[0]), .i_p0_wreg(rwreg[0]), .i_p0_wdata(rwdata[0]), .o_p0_ack(ack[0]),
      .i_p1_req(req[1]), .i_p1_wreg(rwreg[1]), .i_p1_wdata(rwdata[1]), .o_p1_ack(ack[1]),
      .o_rf_we(rf_we), .o_rf_wreg(rf_wreg), .o_rf_wdata(rf_wdata), .o_rf_src(rf_src),
      .o_busy(busy), .o_starve(starve)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: slot contents, who is waiting, and whose turn it is.
   bit            m_valid = 1'b0;
   bit            m_pend [2];
   logic [RW-1:0] m_sreg [2];
   logic [DW-1:0] m_sdata [2];
   int            m_turn;
   int            m_age [2];
   bit            e_we, e_ack [2], e_busy, e_starve;
   logic [RW-1:0] e_wreg;
   logic [DW-1:0] e_wdata;
   int            e_src;

   always @(posedge clk) begin
      int sel;
      bit cap [2];
      if (rst) begin
         m_valid = 1'b1;
         m_turn  = 0;
         e_we = 0; e_wreg = '0; e_wdata = '0; e_src = 0; e_busy = 0; e_starve = 0;
         for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_age[k] = 0; e_ack[k] = 0;
         end
      end else if (m_valid) begin
         sel = -1;
         if (proc_we) begin
            e_we = 1; e_src = 1; e_wreg = proc_wreg; e_wdata = proc_wdata;
         end else begin
            if (m_pend[0] && m_pend[1]) begin
               sel = m_turn; m_turn = 1 - m_turn;
            end else if (m_pend[0] || m_pend[1]) begin
               sel = m_pend[0] ? 0 : 1; m_turn = 1 - sel;
            end
            if (sel >= 0) begin
               e_we = (m_sreg[sel] != 0); e_src = 2 + sel;
               e_wreg = m_sreg[sel]; e_wdata = m_sdata[sel];
            end else begin
               e_we = 0; e_src = 0;
            end
         end
         for (int k = 0; k < 2; k++) begin
            cap[k] = req[k] && !m_pend[k] && !e_ack[k];
            m_age[k] = (m_pend[k] && sel != k) ? m_age[k] + 1 : 0;
`ifdef RF_WRITE_ARBITER_STARVE_EN
            if (m_age[k] >= SM) e_starve = 1;
`endif
         end
         for (int k = 0; k < 2; k++) begin
            if (sel == k) m_pend[k] = 0;
            if (cap[k]) begin
               m_pend[k] = 1; m_sreg[k] = rwreg[k]; m_sdata[k] = rwdata[k];
            end
            e_ack[k] = cap[k];
         end
         e_busy = m_pend[0] || m_pend[1];
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_rf_we", rf_we, e_we);
         chk("m_rf_src", rf_src, e_src[1:0]);
         chk("m_rf_wreg", rf_wreg, e_wreg);
         chk("m_rf_wdata", rf_wdata, e_wdata);
         chk("m_ack0", ack[0], e_ack[0]);
         chk("m_ack1", ack[1], e_ack[1]);
         chk("m_busy", busy, e_busy);
         chk("m_starve", starve, e_starve);
      end
   end

   task automatic set_req(input int k, input logic [RW-1:0] r, input logic [DW-1:0] d);
      req[k] = 1'b1; rwreg[k] = r; rwdata[k] = d;
   endtask

   initial begin
      bit hold [2];
      rst = 1'b1; proc_we = 1'b0; proc_wreg = '0; proc_wdata = '0;
      for (int k = 0; k < 2; k++) begin
         req[k] = 1'b0; rwreg[k] = '0; rwdata[k] = '0; hold[k] = 0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Idle after reset
      repeat (5) @(negedge clk);
      chk("rst_we", rf_we, 0);       chk("rst_wreg", rf_wreg, 0);
      chk("rst_wdata", rf_wdata, 0); chk("rst_src", rf_src, 0);
      chk("rst_ack0", ack[0], 0);    chk("rst_ack1", ack[1], 0);
      chk("rst_busy", busy, 0);      chk("rst_starve", starve, 0);

      // Processor write, latency 1
      proc_we = 1'b1; proc_wreg = 5'd3; proc_wdata = 32'hAB;
      @(negedge clk);
      chk("proc_we", rf_we, 1); chk("proc_wreg", rf_wreg, 3);
      chk("proc_wdata", rf_wdata, 32'hAB); chk("proc_src", rf_src, 2'b01);
      proc_we = 1'b0;

      // Single p0 request held through its ack cycle
      set_req(0, 5'd5, 32'h11);
      @(negedge clk);
      chk("p0_ack", ack[0], 1); chk("p0_busy", busy, 1);
      @(negedge clk);
      chk("p0_src", rf_src, 2'b10); chk("p0_wreg", rf_wreg, 5);
      chk("p0_wdata", rf_wdata, 32'h11); chk("p0_we", rf_we, 1);
      chk("p0_noack2", ack[0], 0); chk("p0_busy_clr", busy, 0);
      req[0] = 1'b0;
      @(negedge clk);
      chk("p0_nodouble", ack[0], 0); chk("idle_we", rf_we, 0);
      chk("idle_src", rf_src, 0); chk("idle_hold_wreg", rf_wreg, 5);

      // Contention with the pointer freshly at p0
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_req(0, 5'd7, 32'h70); set_req(1, 5'd9, 32'h90);
      @(negedge clk);
      chk("both_ack0", ack[0], 1); chk("both_ack1", ack[1], 1);
      req[0] = 1'b0; req[1] = 1'b0;
      @(negedge clk);
      chk("rr_first_src", rf_src, 2'b10); chk("rr_first_wreg", rf_wreg, 7);
      @(negedge clk);
      chk("rr_second_src", rf_src, 2'b11); chk("rr_second_wreg", rf_wreg, 9);
      set_req(0, 5'd10, 32'hA0); set_req(1, 5'd11, 32'hB0);
      @(negedge clk);
      req[0] = 1'b0; req[1] = 1'b0;
      @(negedge clk);
      chk("rr_again_src", rf_src, 2'b10);
      @(negedge clk);
      chk("rr_again_src2", rf_src, 2'b11);

      // Processor holds the port for 20 cycles while p1 waits
      proc_we = 1'b1; proc_wreg = 5'd0; proc_wdata = 32'd100;
      set_req(1, 5'd12, 32'h55);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("defer_src", rf_src, 2'b01);
         chk("defer_we", rf_we, 1);
         if (i == 0) begin
            chk("defer_ack1", ack[1], 1);
            req[1] = 1'b0;
         end else begin
            chk("defer_busy", busy, 1);
         end
         if (i < 19) begin
            proc_wreg = 5'(i + 1); proc_wdata = 32'(i + 101);
         end else begin
            proc_we = 1'b0;
         end
      end
      @(negedge clk);
      chk("defer_p1_src", rf_src, 2'b11); chk("defer_p1_wreg", rf_wreg, 12);
      chk("defer_p1_wdata", rf_wdata, 32'h55);
`ifdef RF_WRITE_ARBITER_STARVE_EN
      chk("starve_set", starve, 1);
      @(negedge clk);
      chk("starve_sticky", starve, 1);
`else
      chk("starve_off", starve, 0);
      @(negedge clk);
`endif

      // Reset with both slots pending and the pointer at p1
      set_req(0, 5'd13, 32'h13);
      @(negedge clk);
      req[0] = 1'b0;
      @(negedge clk);
      chk("pre_rst_src", rf_src, 2'b10);
      proc_we = 1'b1; proc_wreg = 5'd1; proc_wdata = 32'h1;
      set_req(0, 5'd14, 32'hE0); set_req(1, 5'd15, 32'hF0);
      @(negedge clk);
      chk("pre_rst_ack0", ack[0], 1); chk("pre_rst_ack1", ack[1], 1);
      req[0] = 1'b0; req[1] = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1; proc_we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("post_rst_we", rf_we, 0); chk("post_rst_busy", busy, 0);
      chk("post_rst_src", rf_src, 0); chk("post_rst_wreg", rf_wreg, 0);
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_nowrite", rf_we, 0); chk("post_rst_idle", busy, 0);
      end
      set_req(0, 5'd16, 32'h160); set_req(1, 5'd17, 32'h170);
      @(negedge clk);
      req[0] = 1'b0; req[1] = 1'b0;
      @(negedge clk);
      chk("ptr_reset_src", rf_src, 2'b10); chk("ptr_reset_wreg", rf_wreg, 16);

      // Random traffic, checked every cycle by the model
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 299) == 0);
         proc_we = ($urandom_range(0, 99) < ((c / 500) % 2 == 1 ? 85 : 40));
         proc_wreg = RW'($urandom); proc_wdata = $urandom;
         for (int k = 0; k < 2; k++) begin
            if (req[k] && ack[k]) begin
               if ($urandom_range(0, 1) == 1) hold[k] = 1;
               else req[k] = 1'b0;
            end else if (req[k] && hold[k]) begin
               req[k] = 1'b0; hold[k] = 0;
            end else if (!req[k] && $urandom_range(0, 2) == 0) begin
               set_req(k, RW'($urandom), $urandom);
            end
         end
      end
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the regfile write port between the processor writeback path and two hardware requesters, e.g. a guitar-input capture unit and a note-hit scorer.
- Sits between processor_processor / peripherals and regfile. It drives the regfile write enable, write register and write data.
- The processor has absolute priority because it cannot stall. Peripheral writes are buffered in one-deep hold slots and drained round-robin in cycles when the processor is not writing.

Parameters:
- DATA_W, 32, write data width.
- REG_W, 5, register index width.
- STARVE_MAX, 15, cycles a slot may stay pending before the starvation flag sets (optional feature only).

Ports:
- clock  in  1  master clock; the same clock as the processor and regfile.
- reset  in  1  synchronous, active-high reset.
- proc_we  in  1  processor regfile write enable.
- proc_wreg  in  REG_W  processor destination register.
- proc_wdata  in  DATA_W  processor write data.
- p0_req  in  1  peripheral 0 write request (level).
- p0_wreg  in  REG_W  peripheral 0 destination register.
- p0_wdata  in  DATA_W  peripheral 0 write data.
- p0_ack  out  1  one-cycle pulse: peripheral 0 request accepted into its slot.
- p1_req, p1_wreg, p1_wdata, p1_ack: same as p0, for peripheral 1.
- rf_we  out  1  regfile write enable.
- rf_wreg  out  REG_W  regfile write register.
- rf_wdata  out  DATA_W  regfile write data.
- rf_src  out  2  source of the current write: 00 none, 01 proc, 10 p0, 11 p1.
- busy  out  1  at least one peripheral slot is pending.
- starve  out  1  sticky starvation flag; tied 0 unless the optional feature is enabled.

Behaviour:
- Reset values:
  - rf_we, rf_wreg, rf_wdata, rf_src, p0_ack, p1_ack, busy, starve all 0.
  - Both slots empty; round-robin pointer at p0.
- All outputs are registered. A write selected in cycle N appears on rf_* in cycle N+1 (latency 1).
- Capture, per peripheral k:
  - If pk_req=1, slot k is empty and pk_ack=0, latch wreg/wdata into slot k, set pending_k, and pulse pk_ack next cycle.
  - A req still high while ack=1 is ignored; this prevents a double capture. The requester drops req upon seeing ack.
  - A req arriving while slot k is pending waits; no ack is given until the slot drains and a capture occurs.
- Selection each cycle, priority order:
  - proc_we=1: select the processor. Pass its wreg/wdata through unmodified, including wreg=0; regfile ignores r0.
  - Otherwise, both slots pending: select the slot named by the pointer, then toggle the pointer.
  - Otherwise, one slot pending: select it and set the pointer to the other slot.
  - Otherwise: rf_we=0, rf_src=00. rf_wreg/rf_wdata hold their previous values.
- A selected slot clears pending in that cycle. A new capture into that slot is allowed no earlier than the following cycle.
- Peripheral write to wreg=0: the slot drains normally with rf_src set, but rf_we=0.
- busy = pending_0 | pending_1, registered.
- Simultaneous p0/p1 captures in the same cycle are both accepted; both acks pulse together.
- Reset mid-operation: pending slots are discarded without a write, and any in-flight ack is suppressed.
- No combinational path from any input to any output.

Optional Feature:
- Macro RF_WRITE_ARBITER_STARVE_EN.
- With the macro defined:
  - Each slot has a saturating counter that increments every cycle the slot is pending but not selected, and clears when the slot drains or on reset.
  - When any counter reaches STARVE_MAX, starve sets to 1 and stays 1 until reset.
- Without the macro: no counters are built and starve is constant 0.

Test Plan:
- Reset, then idle for 5 cycles -> all outputs 0, busy=0.
- proc_we=1, wreg=3, wdata=0xAB in cycle N -> cycle N+1: rf_we=1, rf_wreg=3, rf_wdata=0xAB, rf_src=01.
- p0_req with wreg=5, wdata=0x11, proc idle -> p0_ack pulses 1 cycle. Write appears with rf_src=10. Holding req through the ack cycle causes no second capture.
- p0 and p1 both pending, proc idle -> p0 written first, then p1 on the next cycle. A further contention is won by p0.
- proc_we held high for 20 cycles while p1 is pending -> p1 write deferred until proc_we drops, then written next cycle. With RF_WRITE_ARBITER_STARVE_EN and STARVE_MAX=15, starve=1 and stays 1.
- reset asserted while both slots are pending -> no rf_we after reset, busy=0, pointer back at p0.
